// File: rtl/led_chaser.sv
// -----------------------------------------------------------------------------
// led_chaser
//
// Running-light generator for a chain of LED boards driven from one clock.
// A single lit "head" LED moves across BOARDS*WIDTH LEDs once every DIV
// clock cycles. It can rotate up, rotate down, bounce between the ends, or
// hold in place. Each WIDTH-bit slice of `leds` drives one board. Slice 0 is
// the master board; the higher slices are forwarded to the slave boards.
//
// Optional feature:
//   LED_CHASER_TAIL_EN - when defined, the previous head position is also
//                        lit, which gives a two-LED comet.
//
// Parameters:
//   BOARDS - number of boards in the chain (>= 1)
//   WIDTH  - LEDs per board (>= 1)
//   DIV    - clock cycles per step (>= 1)
//
// Ports:
//   clk   in  1   system clock, rising edge
//   rst   in  1   asynchronous active-high reset
//   Start in  1   run enable; low forces idle
//   mode  in  2   00 rotate up, 01 rotate down, 10 bounce, 11 hold
//   leds  out N   LED pattern, N = BOARDS*WIDTH
//   pos   out PW  index of the head LED
//   step  out 1   one-cycle pulse, first cycle a new pattern is shown
//   wrap  out 1   one-cycle pulse with step when the head wraps or reverses
// -----------------------------------------------------------------------------
module led_chaser #(
  parameter  int BOARDS = 3,
  parameter  int WIDTH  = 8,
  parameter  int DIV    = 50000000,
  localparam int N      = BOARDS * WIDTH,
  localparam int PW     = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Start,
  input  logic [1:0]    mode,
  output logic [N-1:0]  leds,
  output logic [PW-1:0] pos,
  output logic          step,
  output logic          wrap
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  state_t        state_reg;
  dir_t          dir_reg;
  logic [CW-1:0] cnt_reg;

  // Head position and direction to use when seeding from IDLE
  logic [PW-1:0] seed_pos;
  dir_t          seed_dir;

  // Head position, direction and wrap flag that a step would produce
  logic [PW-1:0] step_pos;
  dir_t          step_dir;
  logic          step_wrap;

  logic [N-1:0]  seed_leds;
  logic [N-1:0]  step_leds;

`ifdef LED_CHASER_TAIL_EN
  logic [PW-1:0] prev_reg;
`endif

  // A rotate-down start seeds at the top and faces down, so that a later
  // switch to bounce keeps moving down.
  always_comb begin
    seed_pos = '0;
    seed_dir = DIR_UP;
    if (mode == 2'b01) begin
      seed_pos = POS_LAST;
      seed_dir = DIR_DOWN;
    end
  end

  always_comb begin
    step_pos  = pos;
    step_dir  = dir_reg;
    step_wrap = 1'b0;
    case (mode)
      2'b00: begin
        step_dir = DIR_UP;
        if (pos == POS_LAST) begin
          step_pos  = '0;
          step_wrap = 1'b1;
        end else begin
          step_pos = pos + PW'(1);
        end
      end
      2'b01: begin
        step_dir = DIR_DOWN;
        if (pos == '0) begin
          step_pos  = POS_LAST;
          step_wrap = 1'b1;
        end else begin
          step_pos = pos - PW'(1);
        end
      end
      2'b10: begin
        // Reversal moves one position away from the end in the same step,
        // so each end LED is shown for only one step.
        if (dir_reg == DIR_UP && pos == POS_LAST) begin
          step_pos  = POS_LAST - PW'(1);
          step_dir  = DIR_DOWN;
          step_wrap = 1'b1;
        end else if (dir_reg == DIR_DOWN && pos == '0) begin
          step_pos  = PW'(1);
          step_dir  = DIR_UP;
          step_wrap = 1'b1;
        end else if (dir_reg == DIR_UP) begin
          step_pos = pos + PW'(1);
        end else begin
          step_pos = pos - PW'(1);
        end
      end
      default: ;  // hold: head and direction unchanged
    endcase
  end

  // One-hot decode of the next pattern. With the tail enabled, the outgoing
  // head position (current pos) stays lit alongside the new head. In hold
  // mode both are the same LED.
  for (genvar gi = 0; gi < N; gi++) begin : g_dec
    assign seed_leds[gi] = (seed_pos == PW'(gi));
`ifdef LED_CHASER_TAIL_EN
    assign step_leds[gi] = (step_pos == PW'(gi)) | (pos == PW'(gi));
`else
    assign step_leds[gi] = (step_pos == PW'(gi));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      dir_reg   <= DIR_UP;
      cnt_reg   <= '0;
      leds      <= '0;
      pos       <= '0;
      step      <= 1'b0;
      wrap      <= 1'b0;
`ifdef LED_CHASER_TAIL_EN
      prev_reg  <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          wrap    <= 1'b0;
          if (Start) begin
            state_reg <= RUN;
            pos       <= seed_pos;
            dir_reg   <= seed_dir;
            leds      <= seed_leds;
            step      <= 1'b1;
`ifdef LED_CHASER_TAIL_EN
            prev_reg  <= seed_pos;
`endif
          end else begin
            leds <= '0;
            step <= 1'b0;
          end
        end
        default: begin  // RUN
          if (!Start) begin
            // Stopping takes priority over a step due in the same cycle.
            state_reg <= IDLE;
            dir_reg   <= DIR_UP;
            cnt_reg   <= '0;
            leds      <= '0;
            pos       <= '0;
            step      <= 1'b0;
            wrap      <= 1'b0;
`ifdef LED_CHASER_TAIL_EN
            prev_reg  <= '0;
`endif
          end else if (cnt_reg == CNT_LAST) begin
            cnt_reg  <= '0;
            pos      <= step_pos;
            dir_reg  <= step_dir;
            leds     <= step_leds;
            step     <= 1'b1;
            wrap     <= step_wrap;
`ifdef LED_CHASER_TAIL_EN
            prev_reg <= pos;
`endif
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
            step    <= 1'b0;
            wrap    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_chaser.sv
// -----------------------------------------------------------------------------
// tb_led_chaser
//
// Directed bench for led_chaser with BOARDS=2, WIDTH=4, DIV=4 (N=8).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_led_chaser;

  logic       clk = 1'b0;
  logic       rst;
  logic       Start;
  logic [1:0] mode;
  logic [7:0] leds;
  logic [2:0] pos;
  logic       step;
  logic       wrap;

  int checks = 0;
  int passed = 0;

`ifdef LED_CHASER_TAIL_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif

  led_chaser #(.BOARDS(2), .WIDTH(4), .DIV(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .Start(Start),
    .mode (mode),
    .leds (leds),
    .pos  (pos),
    .step (step),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  // Expected pattern for head p with previous head q
  function automatic logic [7:0] exp_leds(int p, int q);
    logic [7:0] r;
    r = 8'h01 << p;
    if (TAIL_EN) r = r | (8'h01 << q);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; Start = 1'b0; mode = 2'b00;
    repeat (2) @(negedge clk);
    checks++; if ({leds, pos, step, wrap} !== 13'h0) $display("FAIL reset_state leds=%h pos=%0d step=%b wrap=%b expected all 0", leds, pos, step, wrap); else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({leds, step} !== 9'h0) $display("FAIL idle_quiet leds=%h step=%b expected 00/0", leds, step); else passed++;
    Start = 1'b1;
    @(negedge clk);
    checks++; if (leds !== 8'h01 || step !== 1'b1) $display("FAIL seed_up leds=%h step=%b expected 01/1", leds, step); else passed++;
    repeat (4) @(negedge clk);
    checks++; if (leds !== exp_leds(1, 0) || pos !== 3'd1 || step !== 1'b1) $display("FAIL first_step leds=%h pos=%0d step=%b expected %h/1/1", leds, pos, step, exp_leds(1, 0)); else passed++;
    // Reset asserted mid-cycle must clear outputs before the next edge
    #2 rst = 1'b1;
    #1;
    checks++; if ({leds, pos, step, wrap} !== 13'h0) $display("FAIL async_reset leds=%h pos=%0d step=%b wrap=%b expected all 0", leds, pos, step, wrap); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (leds !== 8'h01 || pos !== 3'd0 || step !== 1'b1) $display("FAIL reseed_after_reset leds=%h pos=%0d step=%b expected 01/0/1", leds, pos, step); else passed++;
  endtask

  task automatic test_rotate_up();
    int p, q, last_p;
    Start = 1'b0; mode = 2'b00;
    @(negedge clk);
    Start = 1'b1;
    last_p = 0;
    for (int k = 0; k < 9; k++) begin
      p = k % 8;
      q = (k == 0) ? p : last_p;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++; if (leds !== exp_leds(p, q)) $display("FAIL up_leds k=%0d c=%0d leds=%h expected %h", k, c, leds, exp_leds(p, q)); else passed++;
        checks++; if (step !== (c == 0)) $display("FAIL up_step k=%0d c=%0d step=%b expected %b", k, c, step, (c == 0)); else passed++;
        if (c == 0) begin
          checks++; if (pos !== 3'(p)) $display("FAIL up_pos k=%0d pos=%0d expected %0d", k, pos, p); else passed++;
          checks++; if (wrap !== (k == 8)) $display("FAIL up_wrap k=%0d wrap=%b expected %b", k, wrap, (k == 8)); else passed++;
        end else begin
          checks++; if (wrap !== 1'b0) $display("FAIL up_wrap_idle k=%0d c=%0d wrap=%b expected 0", k, c, wrap); else passed++;
        end
      end
      last_p = p;
    end
  endtask

  task automatic test_rotate_down();
    int p, q, last_p;
    Start = 1'b0; mode = 2'b01;
    @(negedge clk);
    checks++; if (leds !== 8'h00 || step !== 1'b0) $display("FAIL down_stopped leds=%h step=%b expected 00/0", leds, step); else passed++;
    Start = 1'b1;
    last_p = 7;
    for (int k = 0; k < 9; k++) begin
      p = (15 - k) % 8;
      q = (k == 0) ? p : last_p;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++; if (leds !== exp_leds(p, q)) $display("FAIL down_leds k=%0d c=%0d leds=%h expected %h", k, c, leds, exp_leds(p, q)); else passed++;
        if (c == 0) begin
          checks++; if (step !== 1'b1 || pos !== 3'(p)) $display("FAIL down_step k=%0d step=%b pos=%0d expected 1/%0d", k, step, pos, p); else passed++;
          checks++; if (wrap !== (k == 8)) $display("FAIL down_wrap k=%0d wrap=%b expected %b", k, wrap, (k == 8)); else passed++;
        end
      end
      last_p = p;
    end
  endtask

  task automatic test_bounce();
    int p, q, last_p;
    int hp[5];
    bit hw[5];
    hp = '{5, 5, 6, 7, 6};
    hw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    Start = 1'b0; mode = 2'b10;
    @(negedge clk);
    Start = 1'b1;
    last_p = 0;
    // pos: 0..7, 6..0, 1..5
    for (int k = 0; k < 20; k++) begin
      p = (k <= 7) ? k : ((k <= 14) ? 14 - k : k - 14);
      q = (k == 0) ? p : last_p;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++; if (leds !== exp_leds(p, q)) $display("FAIL bounce_leds k=%0d c=%0d leds=%h expected %h", k, c, leds, exp_leds(p, q)); else passed++;
        if (c == 0) begin
          checks++; if (pos !== 3'(p) || step !== 1'b1) $display("FAIL bounce_pos k=%0d pos=%0d step=%b expected %0d/1", k, pos, step, p); else passed++;
          checks++; if (wrap !== (k == 8 || k == 15)) $display("FAIL bounce_wrap k=%0d wrap=%b expected %b", k, wrap, (k == 8 || k == 15)); else passed++;
        end
      end
      last_p = p;
    end
    // Two hold steps at pos 5, then bounce resumes upward and reverses at 7
    for (int j = 0; j < 5; j++) begin
      mode = (j < 2) ? 2'b11 : 2'b10;
      p = hp[j];
      q = last_p;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++; if (leds !== exp_leds(p, q)) $display("FAIL hold_leds j=%0d c=%0d leds=%h expected %h", j, c, leds, exp_leds(p, q)); else passed++;
        checks++; if (step !== (c == 0)) $display("FAIL hold_step j=%0d c=%0d step=%b expected %b", j, c, step, (c == 0)); else passed++;
        if (c == 0) begin
          checks++; if (pos !== 3'(p) || wrap !== hw[j]) $display("FAIL hold_pos j=%0d pos=%0d wrap=%b expected %0d/%b", j, pos, wrap, p, hw[j]); else passed++;
        end
      end
      last_p = p;
    end
  endtask

  task automatic test_stop_restart();
    Start = 1'b0; mode = 2'b00;
    @(negedge clk);
    Start = 1'b1;
    repeat (4) @(negedge clk);
    // The next edge would step; dropping Start now must suppress it
    Start = 1'b0;
    @(negedge clk);
    checks++; if ({leds, pos, step, wrap} !== 13'h0) $display("FAIL stop_on_step leds=%h pos=%0d step=%b wrap=%b expected all 0", leds, pos, step, wrap); else passed++;
    repeat (2) @(negedge clk);
    checks++; if (leds !== 8'h00 || step !== 1'b0) $display("FAIL stop_idle leds=%h step=%b expected 00/0", leds, step); else passed++;
    Start = 1'b1;
    @(negedge clk);
    checks++; if (leds !== 8'h01 || pos !== 3'd0 || step !== 1'b1) $display("FAIL restart_seed leds=%h pos=%0d step=%b expected 01/0/1", leds, pos, step); else passed++;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      checks++; if (leds !== 8'h01 || step !== 1'b0) $display("FAIL restart_hold c=%0d leds=%h step=%b expected 01/0", c, leds, step); else passed++;
    end
    @(negedge clk);
    checks++; if (leds !== exp_leds(1, 0) || pos !== 3'd1 || step !== 1'b1) $display("FAIL restart_step leds=%h pos=%0d step=%b expected %h/1/1", leds, pos, step, exp_leds(1, 0)); else passed++;
    Start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, checks=%0d passed=%0d", checks, passed);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rotate_up();
    test_rotate_down();
    test_bounce();
    test_stop_restart();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/led_chaser.md
# led_chaser

Parametrised running-light generator driving a chain of LED boards from one clock. Successor to the fixed 24-LED, 3-board shifter. Board count, board width, step period and motion mode are all selectable, with explicit start/stop control and wrap/step status. Sits at the top level on the master board. Each `WIDTH`-bit slice of `leds` drives one board; slices above the master slice are forwarded to slave boards, which display their input unchanged.

## Interface

Parameters:
- `BOARDS`, default 3: number of LED boards in the chain; must be ≥ 1.
- `WIDTH`, default 8: LEDs per board; must be ≥ 1.
- `DIV`, default 50000000: clock cycles per step; must be ≥ 1.
- Derived `N = BOARDS*WIDTH`, required ≥ 2; `PW = max(1, clog2(N))`.

Ports:
- `clk` in 1: system clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `Start` in 1: run enable, sampled synchronously; low forces idle.
- `mode` in 2: motion mode. 00 rotate up, 01 rotate down, 10 bounce, 11 hold.
- `leds` out N: LED pattern. Bits `[WIDTH-1:0]` are the master board; slice k is board k.
- `pos` out PW: index of the lit head LED.
- `step` out 1: one-cycle pulse, high in the first cycle a new pattern is shown.
- `wrap` out 1: one-cycle pulse coincident with `step` when the head wraps or reverses.

## Operation

- States: IDLE, RUN.
- Reset value of every output and register: state IDLE, `leds`=0, `pos`=0, dir=up, divider count=0, `step`=0, `wrap`=0.
- **IDLE:** `leds`=0, count held at 0.
  - If `Start`=1, go to RUN next edge.
  - Seed `pos`=N-1 if `mode`=01; otherwise seed `pos`=0 and dir=up.
  - `step`=1 on the seeding edge.
- **RUN**, when `Start`=0: return to IDLE next edge. Clear `leds`, count, `pos` and dir to reset values; no `step` pulse.
- **RUN**, when `Start`=1: count increments every cycle. At count==DIV-1, count returns to 0 and a step occurs, acting on `mode` sampled that cycle:
  - 00: `pos` = (pos==N-1) ? 0 : pos+1. `wrap`=1 when pos was N-1. dir forced up.
  - 01: `pos` = (pos==0) ? N-1 : pos-1. `wrap`=1 when pos was 0. dir forced down.
  - 10: if dir=up and pos==N-1, then pos=N-2, dir=down, `wrap`=1. If dir=down and pos==0, then pos=1, dir=up, `wrap`=1. Otherwise move one in the current dir.
  - 11: `pos` and dir unchanged, `step` still pulses, `wrap`=0.
- Mode changes take effect only at the next step; they never reseed. Bounce entered from rotate-down starts moving down.
- `leds` = one-hot(`pos`) in RUN (see Configuration).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Timing

- `Start` rising: first pattern visible 1 cycle later.
- Subsequent steps occur every DIV cycles. With DIV=1, a step occurs every cycle.
- `step` and `wrap` are high exactly one cycle, the cycle after the updating edge. They are never high in IDLE except on the seeding cycle.
- `Start` falling: `leds`=0 one cycle later. A step due in that same cycle is suppressed.
- `rst` asserted mid-run: all outputs go to reset values immediately, without waiting for a clock edge. After release, operation resumes only via IDLE→RUN seeding.
- Count width is clog2(DIV), minimum 1 bit. No overflow is possible because count never exceeds DIV-1.

## Configuration

- Macro: `LED_CHASER_TAIL_EN`.
- **Defined:** a `prev` register (reset 0, seeded equal to `pos`) captures the old `pos` at every step that moves the head. In RUN, `leds` = one-hot(`pos`) | one-hot(`prev`), giving a two-LED comet.
  - On seeding, only one LED is lit.
  - In hold mode, `prev` becomes equal to `pos` at the first hold step.
- **Undefined:** no `prev` register; `leds` is strictly one-hot in RUN.

## Test plan

Bench parameters: BOARDS=2, WIDTH=4, DIV=4, so N=8.

- Reset: `rst` pulse mid-cycle with `Start`=1 → all outputs 0 immediately, before the next edge. After release, `Start` held → `leds`=8'h01 one cycle later, with `step`=1.
- Rotate up (`mode`=00, `Start`=1 held):
  - `leds` = 01, 02, 04, … 80, then 01, each held 4 cycles.
  - Lower nibble (master) and upper nibble (board 1) hand over cleanly between 08 and 10.
  - `wrap`=1 only on the 80→01 step.
- Rotate down (`mode`=01): seeds at 8'h80, then 40, 20, … 01, 80. `wrap`=1 on the 01→80 step.
- Bounce (`mode`=10):
  - Sequence of `pos`: 0,1,…,7,6,…,0,1.
  - `wrap` pulses at the 7→6 and 0→1 steps only.
  - Switch to 11 at pos=5 → pos stays 5 and `step` keeps pulsing every 4 cycles. Switch back to 10 → motion resumes in the prior direction.
- Stop/restart:
  - Drop `Start` at the same cycle a step is due → `leds`=0 next cycle, no `step`.
  - Re-raise → reseeded to pos=0, count restarted.
- With `LED_CHASER_TAIL_EN`: rotate up → `leds` = 01, 03, 06, 0C, …, C0, 81, 03.
